uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - byte-framed command decoder driving counter load/enable/clear controls
// Define UART_CMD_CHECKSUM_EN for the 5-byte frame with a trailing XOR checksum; otherwise frames are 4 bytes.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cnt_en,
  output logic        cnt_load,
  output logic [15:0] cnt_load_val,
  output logic        cnt_clr,
  output logic        cmd_err
);

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;
  localparam logic [7:0] CMD_STOP  = 8'h03;
  localparam logic [7:0] CMD_CLEAR = 8'h04;

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_DHI, GET_DLO, GET_CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_DHI, GET_DLO} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  dhi_q, dhi_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  dlo_q, dlo_d;
`endif
  logic [15:0] tmo_q, tmo_d;
  logic        cnt_en_q, cnt_en_d;
  logic        cnt_load_q, cnt_load_d;
  logic [15:0] cnt_load_val_q, cnt_load_val_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        cmd_err_q, cmd_err_d;

  logic        exec;
  logic        chk_ok;
  logic [7:0]  exec_dlo;
  logic [16:0] tmo_inc;

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    dhi_d          = dhi_q;
`ifdef UART_CMD_CHECKSUM_EN
    dlo_d          = dlo_q;
`endif
    tmo_d          = tmo_q;
    cnt_en_d       = cnt_en_q;
    cnt_load_d     = 1'b0;
    cnt_load_val_d = cnt_load_val_q;
    cnt_clr_d      = 1'b0;
    cmd_err_d      = 1'b0;
    exec           = 1'b0;
    chk_ok         = 1'b1;
    exec_dlo       = rx_data;
    tmo_inc        = {1'b0, tmo_q} + 17'd1;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_valid && rx_data == HEADER) state_d = GET_CMD;
      end
      GET_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = GET_DHI;
        end
      end
      GET_DHI: begin
        if (rx_valid) begin
          dhi_d   = rx_data;
          state_d = GET_DLO;
        end
      end
      GET_DLO: begin
        if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
          dlo_d   = rx_data;
          state_d = GET_CHK;
`else
          exec    = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      GET_CHK: begin
        if (rx_valid) begin
          exec     = 1'b1;
          exec_dlo = dlo_q;
          chk_ok   = (rx_data == (cmd_q ^ dhi_q ^ dlo_q));
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A byte arriving on the deadline cycle wins over the timeout.
    if (state_q != IDLE) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_inc >= {1'b0, TIMEOUT_CYCLES}) begin
        tmo_d     = '0;
        state_d   = IDLE;
        cmd_err_d = 1'b1;
      end else begin
        tmo_d = tmo_inc[15:0];
      end
    end

    if (exec) begin
      if (!chk_ok) begin
        cmd_err_d = 1'b1;
      end else begin
        case (cmd_q)
          CMD_LOAD: begin
            cnt_load_val_d = {dhi_q, exec_dlo};
            cnt_load_d     = 1'b1;
          end
          CMD_START: cnt_en_d  = 1'b1;
          CMD_STOP:  cnt_en_d  = 1'b0;
          CMD_CLEAR: cnt_clr_d = 1'b1;
          default:   cmd_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      dhi_q          <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      dlo_q          <= '0;
`endif
      tmo_q          <= '0;
      cnt_en_q       <= 1'b0;
      cnt_load_q     <= 1'b0;
      cnt_load_val_q <= '0;
      cnt_clr_q      <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      dhi_q          <= dhi_d;
`ifdef UART_CMD_CHECKSUM_EN
      dlo_q          <= dlo_d;
`endif
      tmo_q          <= tmo_d;
      cnt_en_q       <= cnt_en_d;
      cnt_load_q     <= cnt_load_d;
      cnt_load_val_q <= cnt_load_val_d;
      cnt_clr_q      <= cnt_clr_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  assign cnt_en       = cnt_en_q;
  assign cnt_load     = cnt_load_q;
  assign cnt_load_val = cnt_load_val_q;
  assign cnt_clr      = cnt_clr_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - randomized and directed bench for uart_cmd_ctrl against a frame-level model
// Honours UART_CMD_CHECKSUM_EN the same way as the design.
module tb_uart_cmd_ctrl;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 12;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clk_in;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cnt_en;
  logic        cnt_load;
  logic [15:0] cnt_load_val;
  logic        cnt_clr;
  logic        cmd_err;

  uart_cmd_ctrl #(.HEADER(HDR), .TIMEOUT_CYCLES(16'(TMO))) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_clr      (cnt_clr),
    .cmd_err      (cmd_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: collects frame bytes in a queue and acts on whole frames.
  logic [7:0]  fq[$];
  int          idle_cnt;
  logic        m_en, m_load, m_clr, m_err;
  logic [15:0] m_val;

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    logic [7:0] c;
    m_load = 0; m_clr = 0; m_err = 0;
    if (r) begin
      fq.delete(); idle_cnt = 0; m_en = 0; m_val = 0;
    end else if (fq.size() == 0) begin
      if (v && d == HDR) begin fq.push_back(d); idle_cnt = 0; end
    end else if (v) begin
      fq.push_back(d);
      idle_cnt = 0;
      if (fq.size() == FLEN) begin
        c = fq[1];
`ifdef UART_CMD_CHECKSUM_EN
        if (fq[4] != (fq[1] ^ fq[2] ^ fq[3])) c = 8'hFF;
`endif
        case (c)
          8'h01: begin m_val = {fq[2], fq[3]}; m_load = 1; end
          8'h02: m_en = 1;
          8'h03: m_en = 0;
          8'h04: m_clr = 1;
          default: m_err = 1;
        endcase
        fq.delete();
      end
    end else begin
      idle_cnt++;
      if (idle_cnt == TMO) begin m_err = 1; fq.delete(); idle_cnt = 0; end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    reset = r; rx_valid = v; rx_data = d;
    @(posedge clk_in);
    model_step(r, v, d);
    #1;
    check_eq("outputs", {12'h0, cnt_en, cnt_load, cnt_clr, cmd_err, cnt_load_val},
             {12'h0, m_en, m_load, m_clr, m_err, m_val});
    check_eq("one_pulse", 32'($countones({cnt_load, cnt_clr, cmd_err}) <= 1), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] ck);
    send(HDR); send(c); send(hi); send(lo);
`ifdef UART_CMD_CHECKSUM_EN
    send(ck);
`else
    if (ck == 8'h00) idle(0);
`endif
  endtask

  initial begin
    logic [7:0] fb[5];
    int         sel;
    fq.delete(); idle_cnt = 0; m_en = 0; m_load = 0; m_clr = 0; m_err = 0; m_val = 0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, HDR);
    check_eq("reset_state", {cnt_en, cnt_load, cnt_clr, cmd_err, cnt_load_val}, 20'h0);
    idle(2);

    // Non-header bytes in idle are ignored.
    send(8'h01); send(8'h33); idle(1);
    check_eq("idle_junk_err", cmd_err, 1'b0);

    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    check_eq("load_pulse", cnt_load, 1'b1);
    check_eq("load_val", cnt_load_val, 16'h1234);
    check_eq("load_no_err", cmd_err, 1'b0);
    idle(1);
    check_eq("load_one_cycle", cnt_load, 1'b0);
    check_eq("load_val_held", cnt_load_val, 16'h1234);

    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    check_eq("start_en", cnt_en, 1'b1);
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    check_eq("stop_en", cnt_en, 1'b0);

`ifdef UART_CMD_CHECKSUM_EN
    send_frame(8'h01, 8'h12, 8'h34, 8'h00);
    check_eq("bad_chk_err", cmd_err, 1'b1);
    check_eq("bad_chk_noload", cnt_load, 1'b0);
    check_eq("bad_chk_val", cnt_load_val, 16'h1234);
`endif

    send_frame(8'h09, 8'h00, 8'h00, 8'h09);
    check_eq("bad_cmd_err", cmd_err, 1'b1);
    check_eq("bad_cmd_quiet", {cnt_en, cnt_load, cnt_clr}, 3'b000);

    send(HDR); send(8'h01); idle(TMO - 1);
    check_eq("tmo_not_yet", cmd_err, 1'b0);
    idle(1);
    check_eq("tmo_err", cmd_err, 1'b1);
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    check_eq("clear_pulse", cnt_clr, 1'b1);

    // Byte landing on the last allowed idle cycle keeps the frame alive.
    send(HDR); send(8'h01); idle(TMO - 1); send(HDR); idle(TMO - 1); send(HDR);
`ifdef UART_CMD_CHECKSUM_EN
    send(8'h01);
`endif
    check_eq("tmo_edge_load", cnt_load, 1'b1);
    check_eq("hdr_as_data", cnt_load_val, 16'hA5A5);

    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    send(HDR); send(8'h02); send(8'h00);
    cycle(1'b1, 1'b1, HDR);
    check_eq("midframe_reset", {cnt_en, cnt_load, cnt_clr, cmd_err, cnt_load_val}, 20'h0);
    send(8'h00); send(8'h02); idle(2);
    check_eq("after_reset_en", cnt_en, 1'b0);
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    check_eq("fresh_frame_en", cnt_en, 1'b1);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 10) begin
        send(8'($urandom));
      end else if (sel < 14) begin
        cycle(1'b1, 1'($urandom), 8'($urandom));
      end else begin
        fb[0] = HDR;
        sel = $urandom_range(0, 5);
        fb[1] = (sel < 4) ? 8'(sel + 1) : 8'($urandom);
        fb[2] = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
        fb[3] = 8'($urandom);
        fb[4] = fb[1] ^ fb[2] ^ fb[3];
        if ($urandom_range(0, 4) == 0) fb[4] = fb[4] ^ 8'(1 << $urandom_range(0, 7));
        for (int b = 0; b < 5; b++) begin
          sel = $urandom_range(0, 19);
          if (sel == 0) idle(TMO);
          else if (sel == 1) idle(TMO - 1);
          else if (sel < 6) idle($urandom_range(1, 3));
          send(fb[b]);
        end
      end
    end
    idle(TMO + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
